// File: rtl/dyn_pre_if_pkg.sv
// dyn_pre_if_pkg: shared opcode constants, 2-bit counter encodings and
// helper functions for the dynamic next-PC predictor.
package dyn_pre_if_pkg;

    // RV32 major opcodes that redirect fetch
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // 2-bit saturating counter encoding; MSB is the taken prediction
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Saturating increment on taken, saturating decrement on not-taken
    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] res;
        if (taken) begin
            if (cnt == ST) begin
                res = ST;
            end else begin
                res = cnt + 2'd1;
            end
        end else begin
            if (cnt == SNT) begin
                res = SNT;
            end else begin
                res = cnt - 2'd1;
            end
        end
        return res;
    endfunction

    // Link registers used by the calling convention (ra = x1, alternate t0 = x5)
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/dyn_pre_if_ras.sv
// dyn_pre_if_ras: return-address stack as a circular buffer with an
// occupancy count. A push when full overwrites the oldest entry; a pop on an
// empty stack is ignored; pop+push together replaces the top in place.
module dyn_pre_if_ras
    import dyn_pre_if_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] push_data_i,
    output logic [31:0] top_o,
    output logic        empty_o
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DEPTH);

    logic [31:0]     buf_q [DEPTH];
    logic [PTRW-1:0] ptr_q;
    logic [PTRW-1:0] ptr_d;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    logic [PTRW-1:0] top_ptr_s;
    logic [PTRW-1:0] wr_ptr_s;
    logic            wr_en_s;
    logic            do_pop_s;

    // ptr_q is the next free slot; the top lives one below it (wraps naturally)
    assign top_ptr_s = ptr_q - PTRW'(1);
    assign do_pop_s  = pop_i && (cnt_q != '0);
    assign top_o     = buf_q[top_ptr_s];
    assign empty_o   = (cnt_q == '0);

    // Next pointer/count and write slot for push, pop, or replace-top
    always_comb begin
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        wr_en_s  = 1'b0;
        wr_ptr_s = ptr_q;
        if (push_i && do_pop_s) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = top_ptr_s;
        end else if (push_i) begin
            wr_en_s  = 1'b1;
            wr_ptr_s = ptr_q;
            ptr_d    = ptr_q + PTRW'(1);
            if (cnt_q == CNT_FULL) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end else if (do_pop_s) begin
            ptr_d = top_ptr_s;
            cnt_d = cnt_q - CNTW'(1);
        end else begin
            ptr_d = ptr_q;
            cnt_d = cnt_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Return-address storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 32'd0;
            end
        end else if (wr_en_s) begin
            buf_q[wr_ptr_s] <= push_data_i;
        end
    end

endmodule

// File: rtl/dyn_pre_if.sv
// dyn_pre_if: same-cycle next-PC predictor for the IF stage.
// Conditional branches use a PC-indexed table of 2-bit saturating counters
// trained by EX; JAL targets are decoded directly.
// Optional feature macro: DYN_PRE_IF_RAS_EN adds a return-address stack that
// predicts jalr returns. Without it, jalr predicts pc+4 and if_valid is unused.
module dyn_pre_if
    import dyn_pre_if_pkg::*;
#(
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic [31:0] pre_pc,
    output logic        pre_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken
);

    localparam int IDXW = $clog2(BHT_DEPTH);

    logic [6:0]      opcode_s;
    logic [31:0]     bimm_s;
    logic [31:0]     jimm_s;
    logic [31:0]     pc_plus4_s;
    logic [IDXW-1:0] lkp_idx_s;
    logic [IDXW-1:0] upd_idx_s;
    logic [1:0]      lkp_cnt_s;
    logic [1:0]      upd_cnt_d;
    logic [1:0]      cnt_q [BHT_DEPTH];
    logic [31:0]     pre_pc_s;
    logic            pre_taken_s;
    logic            unused_ok;

    assign opcode_s   = instr[6:0];
    assign bimm_s     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign jimm_s     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign pc_plus4_s = pc + 32'd4;

    // Untagged direct-mapped indexing; aliasing PCs share a counter
    assign lkp_idx_s = pc[IDXW+1:2];
    assign upd_idx_s = upd_pc[IDXW+1:2];
    assign lkp_cnt_s = cnt_q[lkp_idx_s];
    assign upd_cnt_d = sat_update(cnt_q[upd_idx_s], upd_taken);

    // Branch history table: one counter written per resolved branch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                cnt_q[i] <= CNT_INIT;
            end
        end else if (upd_valid) begin
            cnt_q[upd_idx_s] <= upd_cnt_d;
        end
    end

`ifdef DYN_PRE_IF_RAS_EN
    logic [4:0]  rd_s;
    logic [4:0]  rs1_s;
    logic        is_jal_s;
    logic        is_jalr_s;
    logic        ras_push_s;
    logic        ras_pop_cand_s;
    logic        ras_pop_s;
    logic [31:0] ras_top_s;
    logic        ras_empty_s;

    assign rd_s      = instr[11:7];
    assign rs1_s     = instr[19:15];
    assign is_jal_s  = (opcode_s == OPC_JAL);
    assign is_jalr_s = (opcode_s == OPC_JALR);

    // Calls push the return address; a return pops unless it also links
    // through the same register (that form is a coroutine-style swap).
    assign ras_push_s     = if_valid && (is_jal_s || is_jalr_s) && is_link(rd_s);
    assign ras_pop_cand_s = is_jalr_s && is_link(rs1_s) && !(is_link(rd_s) && (rs1_s == rd_s));
    assign ras_pop_s      = if_valid && ras_pop_cand_s;

    dyn_pre_if_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (ras_push_s),
        .pop_i       (ras_pop_s),
        .push_data_i (pc_plus4_s),
        .top_o       (ras_top_s),
        .empty_o     (ras_empty_s)
    );
`endif

    // Next-PC selection by opcode; independent of if_valid
    always_comb begin
        pre_pc_s    = pc_plus4_s;
        pre_taken_s = 1'b0;
        case (opcode_s)
            OPC_JAL: begin
                pre_taken_s = 1'b1;
                pre_pc_s    = pc + jimm_s;
            end
            OPC_BRANCH: begin
                if (lkp_cnt_s[1]) begin
                    pre_taken_s = 1'b1;
                    pre_pc_s    = pc + bimm_s;
                end else begin
                    pre_taken_s = 1'b0;
                    pre_pc_s    = pc_plus4_s;
                end
            end
            OPC_JALR: begin
`ifdef DYN_PRE_IF_RAS_EN
                if (ras_pop_cand_s && !ras_empty_s) begin
                    pre_taken_s = 1'b1;
                    pre_pc_s    = ras_top_s;
                end else begin
                    pre_taken_s = 1'b0;
                    pre_pc_s    = pc_plus4_s;
                end
`else
                pre_taken_s = 1'b0;
                pre_pc_s    = pc_plus4_s;
`endif
            end
            default: begin
                pre_taken_s = 1'b0;
                pre_pc_s    = pc_plus4_s;
            end
        endcase
    end

    assign pre_pc    = pre_pc_s;
    assign pre_taken = pre_taken_s;

    // Bits that do not take part in every build configuration
    assign unused_ok = &{1'b0, if_valid, (RAS_DEPTH > 0), upd_pc[31:IDXW+2], upd_pc[1:0]};

endmodule

// File: tb/tb_dyn_pre_if.sv
// tb_dyn_pre_if: directed scoreboard bench for dyn_pre_if.
// Honours DYN_PRE_IF_RAS_EN for the jalr expectations.
module tb_dyn_pre_if;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pre_pc;
    logic        pre_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;

    int tests_run;
    int tests_failed;

    logic [31:0] exp_pc_q [$];
    logic        exp_tk_q [$];
    string       tag_q    [$];

    dyn_pre_if #(
        .BHT_DEPTH (64),
        .CNT_INIT  (2'b01),
        .RAS_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .instr     (instr),
        .pc        (pc),
        .pre_pc    (pre_pc),
        .pre_taken (pre_taken),
        .upd_valid (upd_valid),
        .upd_pc    (upd_pc),
        .upd_taken (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] enc_b(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    task automatic check_head();
        logic [31:0] e_pc;
        logic        e_tk;
        string       t;
        tests_run++;
        assert (exp_pc_q.size() > 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_empty: got 0 entries, required at least 1");
        end
        if (exp_pc_q.size() > 0) begin
            e_pc = exp_pc_q.pop_front();
            e_tk = exp_tk_q.pop_front();
            t    = tag_q.pop_front();
            tests_run++;
            assert (pre_pc === e_pc) else begin
                tests_failed++;
                $error("FAIL %s pre_pc: got %h required %h", t, pre_pc, e_pc);
            end
            tests_run++;
            assert (pre_taken === e_tk) else begin
                tests_failed++;
                $error("FAIL %s pre_taken: got %b required %b", t, pre_taken, e_tk);
            end
        end
    endtask

    // Drive one fetch/update cycle, record the expectation, check before the edge
    task automatic step(input logic [31:0] i_instr, input logic [31:0] i_pc, input logic i_iv,
                        input logic i_uv, input logic [31:0] i_upc, input logic i_ut,
                        input logic [31:0] e_pc, input logic e_tk, input string t);
        instr     = i_instr;
        pc        = i_pc;
        if_valid  = i_iv;
        upd_valid = i_uv;
        upd_pc    = i_upc;
        upd_taken = i_ut;
        exp_pc_q.push_back(e_pc);
        exp_tk_q.push_back(e_tk);
        tag_q.push_back(t);
        @(negedge clk);
        check_head();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] bxx_m8;
        logic [31:0] jr_ra;
        logic [31:0] ret_exp;
        logic        ret_tk;
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        if_valid     = 1'b0;
        instr        = 32'h0000_0013;
        pc           = 32'd0;
        upd_valid    = 1'b0;
        upd_pc       = 32'd0;
        upd_taken    = 1'b0;
        bxx_m8       = enc_b(13'h1FF8);
        jr_ra        = enc_jalr(5'd0, 5'd1);
        #1;

        // Reset state: weakly not-taken
        step(bxx_m8, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, "rst_bxx");
        rst_n = 1'b1;

        // Training on pc 0x100: 01 -> 10 -> 11 -> 10 -> 01 -> 00 -> 00 -> 01 -> 10
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, "train_t1");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h0F8, 1'b1, "train_t2");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0F8, 1'b1, "strong_t");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0F8, 1'b1, "weak_t");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h104, 1'b0, "weak_nt");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b0, 32'h104, 1'b0, "snt_floor");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, "no_underflow");
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, "back_to_wnt");
        step(bxx_m8, 32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0F8, 1'b1, "back_to_wt");

        // Aliasing pc 0x100 + 4*64 shares the entry
        step(bxx_m8, 32'h200, 1'b0, 1'b0, 32'h0, 1'b0, 32'h1F8, 1'b1, "alias");

        // Same-cycle lookup and update: old value now, new value next cycle
        step(enc_b(13'h0020), 32'h40, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44, 1'b0, "same_cyc_old");
        step(enc_b(13'h0020), 32'h40, 1'b0, 1'b0, 32'h0,  1'b0, 32'h60, 1'b1, "same_cyc_new");

        // JAL direct targets, including wrap and negative offset
        step(enc_j(5'd0, 21'h000400), 32'h200,      1'b0, 1'b0, 32'h0, 1'b0, 32'h600, 1'b1, "jal_fwd");
        step(enc_j(5'd0, 21'h000008), 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h4,   1'b1, "jal_wrap");
        step(enc_j(5'd0, 21'h1FFFF0), 32'h2000,     1'b0, 1'b0, 32'h0, 1'b0, 32'h1FF0, 1'b1, "jal_neg");

        // Non-control instruction
        step(32'h0000_0013, 32'h1000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h1004, 1'b0, "addi");

        // Call / return pair
        step(enc_j(5'd1, 21'h000100), 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h400, 1'b1, "call");
`ifdef DYN_PRE_IF_RAS_EN
        ret_exp = 32'h304;
        ret_tk  = 1'b1;
`else
        ret_exp = 32'h504;
        ret_tk  = 1'b0;
`endif
        step(jr_ra, 32'h500, 1'b1, 1'b0, 32'h0, 1'b0, ret_exp, ret_tk, "ret1");
        step(jr_ra, 32'h504, 1'b1, 1'b0, 32'h0, 1'b0, 32'h508, 1'b0, "ret_empty");

        // RAS_DEPTH+1 calls then RAS_DEPTH returns: the oldest is lost
        for (int k = 0; k < 5; k++) begin
            step(enc_j(5'd1, 21'h000020), 32'h1000 + 32'h10 * k, 1'b1, 1'b0, 32'h0, 1'b0,
                 32'h1020 + 32'h10 * k, 1'b1, "deep_call");
        end
        for (int k = 0; k < 4; k++) begin
`ifdef DYN_PRE_IF_RAS_EN
            ret_exp = 32'h1044 - 32'h10 * k;
            ret_tk  = 1'b1;
`else
            ret_exp = 32'h2004 + 32'h8 * k;
            ret_tk  = 1'b0;
`endif
            step(jr_ra, 32'h2000 + 32'h8 * k, 1'b1, 1'b0, 32'h0, 1'b0, ret_exp, ret_tk, "deep_ret");
        end
        step(jr_ra, 32'h2100, 1'b1, 1'b0, 32'h0, 1'b0, 32'h2104, 1'b0, "deep_ret_empty");

        // Pop+push in one cycle (jalr x5, 0(x1)) replaces the top
        step(enc_j(5'd1, 21'h000100), 32'h3000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h3100, 1'b1, "swap_call");
`ifdef DYN_PRE_IF_RAS_EN
        ret_exp = 32'h3004;
        ret_tk  = 1'b1;
`else
        ret_exp = 32'h3104;
        ret_tk  = 1'b0;
`endif
        step(enc_jalr(5'd5, 5'd1), 32'h3100, 1'b1, 1'b0, 32'h0, 1'b0, ret_exp, ret_tk, "swap");
`ifdef DYN_PRE_IF_RAS_EN
        ret_exp = 32'h3104;
        ret_tk  = 1'b1;
`else
        ret_exp = 32'h3204;
        ret_tk  = 1'b0;
`endif
        step(enc_jalr(5'd0, 5'd5), 32'h3200, 1'b1, 1'b0, 32'h0, 1'b0, ret_exp, ret_tk, "swap_ret");
        step(jr_ra, 32'h3300, 1'b1, 1'b0, 32'h0, 1'b0, 32'h3304, 1'b0, "swap_empty");

        // Mid-run reset after training and a pending call
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h0F8, 1'b1, "pre_rst_train");
        step(enc_j(5'd1, 21'h000010), 32'h4000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h4010, 1'b1, "pre_rst_call");
        rst_n = 1'b0;
        step(bxx_m8, 32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, "midrst_bxx");
        rst_n = 1'b1;
        step(bxx_m8, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, "post_rst_no_write");
        step(jr_ra, 32'h5000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h5004, 1'b0, "post_rst_ras_empty");

        tests_run++;
        assert (exp_pc_q.size() == 0) else begin
            tests_failed++;
            $error("FAIL scoreboard_drain: got %0d left, required 0", exp_pc_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
